// File: rtl/ping_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ping_ctrl                                                   |
// | Brief    : Ultrasonic ping sequencer: trigger pulse, echo wait, echo   |
// |            width measured in 1 us ticks. Optional macro PING_AUTO_EN   |
// |            makes measurements repeat free-running.                     |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module ping_ctrl #(
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned TIMEOUT_US = 30000,
    parameter int unsigned HOLDOFF_US = 60000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start,
    input  logic        echo,
    output logic        trig,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] width
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TRIG      = 3'd1;
    localparam logic [2:0] S_WAIT_RISE = 3'd2;
    localparam logic [2:0] S_MEASURE   = 3'd3;
    localparam logic [2:0] S_HOLDOFF   = 3'd4;

    localparam logic [15:0] c_trig_last    = 16'(TRIG_US - 1);
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_US - 1);
    localparam logic [15:0] c_holdoff_last = 16'(HOLDOFF_US - 1);
    localparam logic [15:0] c_cnt_max      = 16'hFFFF;

    logic        r_echo_meta;
    logic        r_echo_s;
    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic        r_trig;
    logic        r_busy;
    logic        r_done;
    logic        r_timeout;
    logic [15:0] r_width;

    logic [2:0]  w_state_nxt;
    logic        w_cnt_inc;
    logic        w_report;
    logic        w_timeout_nxt;
    logic [15:0] w_width_nxt;
    logic        w_go;

`ifdef PING_AUTO_EN
    // start is still honoured, but auto arming already leaves IDLE at once
    assign w_go = start | 1'b1;
`else
    assign w_go = start;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_inc     = tick;
        w_report      = 1'b0;
        w_timeout_nxt = 1'b0;
        w_width_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_go) w_state_nxt = S_TRIG;
            end
            S_TRIG: begin
                if (tick && r_cnt == c_trig_last) w_state_nxt = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                // a stale high echo on entry counts as a rise
                if (r_echo_s) begin
                    w_state_nxt = S_MEASURE;
                end else if (tick && r_cnt == c_timeout_last) begin
                    w_state_nxt   = S_HOLDOFF;
                    w_report      = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_width_nxt   = c_cnt_max;
                end
            end
            S_MEASURE: begin
                w_cnt_inc = tick & r_echo_s;
                // echo fall is checked first so it wins over a coincident timeout
                if (!r_echo_s) begin
                    w_state_nxt = S_HOLDOFF;
                    w_report    = 1'b1;
                end else if (tick && r_cnt == c_timeout_last) begin
                    w_state_nxt   = S_HOLDOFF;
                    w_report      = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_width_nxt   = c_cnt_max;
                end
            end
            S_HOLDOFF: begin
                if (tick && r_cnt == c_holdoff_last) begin
`ifdef PING_AUTO_EN
                    w_state_nxt = S_TRIG;
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_echo_meta <= 1'b0;
            r_echo_s    <= 1'b0;
            r_state     <= S_IDLE;
            r_cnt       <= 16'd0;
            r_trig      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_width     <= 16'd0;
        end else begin
            r_echo_meta <= echo;
            r_echo_s    <= r_echo_meta;
            r_state     <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= 16'd0;
            end else if (w_cnt_inc && r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + 16'd1;
            end
            r_trig <= (w_state_nxt == S_TRIG);
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= w_report;
            if (w_report) begin
                r_width   <= w_width_nxt;
                r_timeout <= w_timeout_nxt;
            end
        end
    end

    assign trig    = r_trig;
    assign busy    = r_busy;
    assign done    = r_done;
    assign timeout = r_timeout;
    assign width   = r_width;

endmodule
`default_nettype wire
